// File: rtl/cpu_pkg.sv
// Shared types for the execute stage: ALU opcodes, forwarding selects and
// divider FSM state encodings.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef logic [1:0] div_state_t;
  localparam div_state_t IDLE = 2'd0;
  localparam div_state_t BUSY = 2'd1;
  localparam div_state_t DONE = 2'd2;

  function automatic logic is_div_op(alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Bundle between ID/EX (master) and the execute stage (slave), including the
// EX/MEM register outputs and the divider state for observation.
interface ex_stage_if #(parameter int XLEN = cpu_pkg::XLEN);
  import cpu_pkg::*;

  // Handshake: an instruction is in EX when valid_ex=1. While stall_ex=1 the
  // master must hold every EX input stable; the instruction retires into
  // EX/MEM on the first clock edge with stall_ex=0. flush_ex kills it.
  logic            valid_ex;
  logic            flush_ex;
  alu_op_t         alu_op_ex;
  logic [XLEN-1:0] rs1_data_ex;
  logic [XLEN-1:0] rs2_data_ex;
  logic [XLEN-1:0] imm_ex;
  logic            alu_src_ex;
  logic [1:0]      forwardA;
  logic [1:0]      forwardB;
  logic [XLEN-1:0] fwd_mem_data;
  logic [XLEN-1:0] fwd_wb_data;
  logic [4:0]      rd_ex;
  logic            reg_wr_ex;
  logic            mem_rd_ex;
  logic            mem_wr_ex;

  logic            stall_ex;
  logic            ex_mem_valid;
  logic            ex_mem_reg_wr;
  logic            ex_mem_mem_rd;
  logic            ex_mem_mem_wr;
  logic [4:0]      ex_mem_rd;
  logic [XLEN-1:0] ex_mem_result;
  logic [XLEN-1:0] ex_mem_store_data;
  div_state_t      div_state;

  modport master (
    output valid_ex, flush_ex, alu_op_ex, rs1_data_ex, rs2_data_ex, imm_ex,
           alu_src_ex, forwardA, forwardB, fwd_mem_data, fwd_wb_data,
           rd_ex, reg_wr_ex, mem_rd_ex, mem_wr_ex,
    input  stall_ex, ex_mem_valid, ex_mem_reg_wr, ex_mem_mem_rd, ex_mem_mem_wr,
           ex_mem_rd, ex_mem_result, ex_mem_store_data, div_state
  );

  modport slave (
    input  valid_ex, flush_ex, alu_op_ex, rs1_data_ex, rs2_data_ex, imm_ex,
           alu_src_ex, forwardA, forwardB, fwd_mem_data, fwd_wb_data,
           rd_ex, reg_wr_ex, mem_rd_ex, mem_wr_ex,
    output stall_ex, ex_mem_valid, ex_mem_reg_wr, ex_mem_mem_rd, ex_mem_mem_wr,
           ex_mem_rd, ex_mem_result, ex_mem_store_data, div_state
  );

endinterface

// File: rtl/ex_stage_div_unit.sv
// Iterative radix-2 restoring divider (IDLE/BUSY/DONE) with sign fix-up and
// single-step handling of divide-by-zero and signed overflow.
module div_unit
  import cpu_pkg::*;
#(
  parameter int XLEN      = cpu_pkg::XLEN,
  parameter int DIV_ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output div_state_t      state
);

  localparam int CW = $clog2(DIV_ITERS);

  div_state_t      state_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] quo_q, rem_q, dsor_q;
  logic            neg_quo_q, neg_rem_q, is_rem_q;

  logic            sign_a, sign_b, div_zero, overflow;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   shifted, diff;

  assign sign_a   = is_signed & dividend[XLEN-1];
  assign sign_b   = is_signed & divisor[XLEN-1];
  assign mag_a    = sign_a ? -dividend : dividend;
  assign mag_b    = sign_b ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign overflow = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

  // Partial remainder shifted left with the next dividend bit; a clear MSB of
  // the difference means the divisor fits and the quotient bit is 1.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dsor_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dsor_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            is_rem_q <= is_rem;
            if (div_zero) begin
              quo_q     <= '1;
              rem_q     <= dividend;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= DONE;
            end else if (overflow) begin
              quo_q     <= dividend;
              rem_q     <= '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= DONE;
            end else begin
              quo_q     <= mag_a;
              rem_q     <= '0;
              dsor_q    <= mag_b;
              neg_quo_q <= sign_a ^ sign_b;
              neg_rem_q <= sign_a;
              count_q   <= CW'(DIV_ITERS - 1);
              state_q   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!diff[XLEN]) begin
            rem_q <= diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_q <= shifted[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
          end
          if (count_q == '0) begin
            state_q <= DONE;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result = is_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                           : (neg_quo_q ? -quo_q : quo_q);
  assign busy   = (state_q == BUSY);
  assign done   = (state_q == DONE);
  assign state  = state_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, optional mul/div and the EX/MEM
// register. Build with EX_MULDIV_EN defined to include the multiplier/divider.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN      = cpu_pkg::XLEN,
  parameter int DIV_ITERS = 32
) (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave ex
);

  localparam int SW = $clog2(XLEN);

  if (DIV_ITERS != XLEN) begin : g_bad_iters
    $error("DIV_ITERS must equal XLEN");
  end

  logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_res, md_res;
  logic [SW-1:0]   shamt;
  logic            stall, load;

  always_comb begin
    case (ex.forwardA)
      FWD_MEM: op_a = ex.fwd_mem_data;
      FWD_WB:  op_a = ex.fwd_wb_data;
      default: op_a = ex.rs1_data_ex;
    endcase
    case (ex.forwardB)
      FWD_MEM: rs2_fwd = ex.fwd_mem_data;
      FWD_WB:  rs2_fwd = ex.fwd_wb_data;
      default: rs2_fwd = ex.rs2_data_ex;
    endcase
  end

  assign op_b  = ex.alu_src_ex ? ex.imm_ex : rs2_fwd;
  assign shamt = op_b[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (ex.alu_op_ex)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SLL:   alu_res = op_a << shamt;
      ALU_SRL:   alu_res = op_a >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = md_res;
    endcase
  end

`ifdef EX_MULDIV_EN
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic              a_signed, b_signed;
  logic              div_req, div_busy, div_done, div_signed, div_rem;
  logic [XLEN-1:0]   div_result;

  // One 2*XLEN product serves all four multiplies; only the operand
  // extension differs.
  assign a_signed = (ex.alu_op_ex == ALU_MULH) || (ex.alu_op_ex == ALU_MULHSU);
  assign b_signed = (ex.alu_op_ex == ALU_MULH);
  assign mul_a    = {{XLEN{a_signed & op_a[XLEN-1]}}, op_a};
  assign mul_b    = {{XLEN{b_signed & op_b[XLEN-1]}}, op_b};
  assign product  = mul_a * mul_b;

  assign div_req    = ex.valid_ex && !ex.flush_ex && is_div_op(ex.alu_op_ex);
  assign div_signed = (ex.alu_op_ex == ALU_DIV) || (ex.alu_op_ex == ALU_REM);
  assign div_rem    = (ex.alu_op_ex == ALU_REM) || (ex.alu_op_ex == ALU_REMU);

  div_unit #(.XLEN(XLEN), .DIV_ITERS(DIV_ITERS)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_req),
    .abort     (ex.flush_ex),
    .is_signed (div_signed),
    .is_rem    (div_rem),
    .dividend  (op_a),
    .divisor   (op_b),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result),
    .state     (ex.div_state)
  );

  always_comb begin
    md_res = '0;
    case (ex.alu_op_ex)
      ALU_MUL:                              md_res = product[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:      md_res = product[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: md_res = div_result;
      default:                              md_res = '0;
    endcase
  end

  // Gated by rst so the stall drops together with the asynchronous reset.
  assign stall = !rst && div_req && (div_busy || !div_done);
`else
  assign md_res       = '0;
  assign stall        = 1'b0;
  assign ex.div_state = IDLE;
`endif

  assign ex.stall_ex = stall;
  assign load        = ex.valid_ex && !ex.flush_ex && !stall;

  // Bubbles clear only the control bits; data fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex.ex_mem_valid      <= 1'b0;
      ex.ex_mem_reg_wr     <= 1'b0;
      ex.ex_mem_mem_rd     <= 1'b0;
      ex.ex_mem_mem_wr     <= 1'b0;
      ex.ex_mem_rd         <= '0;
      ex.ex_mem_result     <= '0;
      ex.ex_mem_store_data <= '0;
    end else begin
      ex.ex_mem_valid  <= load;
      ex.ex_mem_reg_wr <= load & ex.reg_wr_ex;
      ex.ex_mem_mem_rd <= load & ex.mem_rd_ex;
      ex.ex_mem_mem_wr <= load & ex.mem_wr_ex;
      if (load) begin
        ex.ex_mem_rd         <= ex.rd_ex;
        ex.ex_mem_result     <= alu_res;
        ex.ex_mem_store_data <= rs2_fwd;
      end
    end
  end

endmodule
